// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int STARVE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DONE
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } arb_owner_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_starve_ctr.sv
// Fetch starvation guard: counts D grants made while fetch waits and forces
// the next contested arbitration to fetch once STARVE_LIMIT is reached.
module arb_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       idle,
    input  logic       i_req,
    input  logic       grant,
    input  mem_bus_arbiter_pkg::arb_owner_t owner,
    output logic       force_i
);
    import mem_bus_arbiter_pkg::*;

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);
    localparam logic [STARVE_W-1:0] ONE   = STARVE_W'(1);

    logic [STARVE_W-1:0] streak;

    assign force_i = (streak >= LIMIT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            streak <= '0;
        end else if (idle) begin
            if (!i_req || (grant && owner == OWN_I)) begin
                streak <= '0;
            end else if (grant && owner == OWN_D && streak < LIMIT) begin
                streak <= streak + ONE;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory bus between fetch (I) and data (D) requesters.
// Defining ARB_PERF_EN adds saturating per-requester wait-cycle counters.
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ok,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_strobe,
    output logic        d_ok,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_write,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_strobe,
    input  logic        m_ok,
    input  logic [31:0] m_rdata,
    output logic        stall
`ifdef ARB_PERF_EN
    ,
    output logic [31:0] i_wait_cnt,
    output logic [31:0] d_wait_cnt
`endif
);
    import mem_bus_arbiter_pkg::*;

    arb_state_t state, state_nxt;
    arb_owner_t owner_q;
    logic       grant_i, grant_d;
    logic       force_i;

    arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .resetn  (resetn),
        .idle    (state == IDLE),
        .i_req   (i_req),
        .grant   (grant_i | grant_d),
        .owner   (grant_d ? OWN_D : OWN_I),
        .force_i (force_i)
    );

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first, so no branch leaves a signal unassigned and infers a latch.
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && !(i_req && force_i)) begin
                    grant_d   = 1'b1;
                    state_nxt = BUSY_D;
                end else if (i_req) begin
                    grant_i   = 1'b1;
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (m_ok) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: the latched bus fields and read data are reset too, so every output reads 0 in reset.
        if (!resetn) begin
            owner_q  <= OWN_I;
            m_write  <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_strobe <= '0;
            i_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            if (grant_i) begin
                owner_q  <= OWN_I;
                m_write  <= 1'b0;
                m_addr   <= i_addr;
                m_wdata  <= '0;
                m_strobe <= '0;
            end else if (grant_d) begin
                owner_q  <= OWN_D;
                m_write  <= d_write;
                m_addr   <= d_addr;
                m_wdata  <= d_wdata;
                m_strobe <= d_strobe;
            end
            if (state == BUSY_I && m_ok) begin
                i_rdata <= m_rdata;
            end
            // Stores leave the last load data in place.
            if (state == BUSY_D && m_ok && !m_write) begin
                d_rdata <= m_rdata;
            end
        end
    end

    // Decoded from the state register so reset drops them without waiting for a clock.
    assign m_req = (state == BUSY_I) || (state == BUSY_D);
    assign i_ok  = (state == DONE) && (owner_q == OWN_I);
    assign d_ok  = (state == DONE) && (owner_q == OWN_D);

    // Gated by resetn so the stall is also 0 while the arbiter is held in reset.
    assign stall = resetn & ((i_req & ~i_ok) | (d_req & ~d_ok));

`ifdef ARB_PERF_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_wait_cnt <= '0;
            d_wait_cnt <= '0;
        end else begin
            if (i_req && !i_ok) begin
                i_wait_cnt <= sat_inc32(i_wait_cnt);
            end
            if (d_req && !d_ok) begin
                d_wait_cnt <= sat_inc32(d_wait_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a randomized
// phase, all compared against a transaction-timeline reference model.
module tb_mem_bus_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        resetn;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ok;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_strobe;
    logic        d_ok;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_write;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_strobe;
    logic        m_ok;
    logic [31:0] m_rdata;
    logic        stall;
`ifdef ARB_PERF_EN
    logic [31:0] i_wait_cnt;
    logic [31:0] d_wait_cnt;
`endif

    mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ok     (i_ok),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_write  (d_write),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_strobe (d_strobe),
        .d_ok     (d_ok),
        .d_rdata  (d_rdata),
        .m_req    (m_req),
        .m_write  (m_write),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_strobe (m_strobe),
        .m_ok     (m_ok),
        .m_rdata  (m_rdata),
        .stall    (stall)
`ifdef ARB_PERF_EN
        ,
        .i_wait_cnt (i_wait_cnt),
        .d_wait_cnt (d_wait_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the current access as a timeline (grant cycle, m_ok cycle).
    int          cyc;
    bit          act, act_d;
    int          g_cyc, k_cyc;
    logic        e_write;
    logic [31:0] e_addr, e_wdata, e_irdata, e_drdata, e_iwait, e_dwait;
    logic [3:0]  e_strobe;
    int          streak;
    bit          e_mreq, e_iok, e_dok;
    bit          last_iok, last_dok;

    // Stimulus controls.
    int          mem_lat;
    bit          mem_rand, auto_req, spurious;
    string       order;
    logic [31:0] obs_iwait;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        act = 0; act_d = 0; g_cyc = 0; k_cyc = -1;
        e_write = 0; e_addr = '0; e_wdata = '0; e_strobe = '0;
        e_irdata = '0; e_drdata = '0; e_iwait = '0; e_dwait = '0;
        streak = 0; cyc = 0; last_iok = 0; last_dok = 0;
    endfunction

    function automatic void predict();
        e_mreq = act && (k_cyc < 0) && (cyc > g_cyc);
        e_iok  = act && !act_d && (k_cyc >= 0) && (cyc == k_cyc + 1);
        e_dok  = act &&  act_d && (k_cyc >= 0) && (cyc == k_cyc + 1);
    endfunction

    function automatic void arbitrate();
        bit win_d;
        win_d = (i_req && d_req) ? (streak < LIMIT) : d_req;
        if (win_d) begin
            act = 1; act_d = 1; g_cyc = cyc; k_cyc = -1;
            e_addr = d_addr; e_write = d_write; e_wdata = d_wdata; e_strobe = d_strobe;
            streak = i_req ? ((streak < LIMIT) ? streak + 1 : LIMIT) : 0;
        end else if (i_req) begin
            act = 1; act_d = 0; g_cyc = cyc; k_cyc = -1;
            e_addr = i_addr; e_write = 0; e_wdata = '0; e_strobe = '0;
            streak = 0;
        end else begin
            streak = 0;
        end
    endfunction

    task automatic drive_auto();
        if (!i_req || last_iok) begin
            i_req  = ($urandom_range(0, 1) == 1);
            i_addr = $urandom();
        end
        if (!d_req || last_dok) begin
            d_req    = ($urandom_range(0, 1) == 1);
            d_write  = ($urandom_range(0, 1) == 1);
            d_addr   = $urandom();
            d_wdata  = $urandom();
            d_strobe = 4'($urandom());
        end
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic step();
        predict();
        if (mem_rand) begin
            m_ok    = e_mreq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            m_rdata = $urandom();
        end else begin
            m_ok = spurious || (e_mreq && (cyc - g_cyc == mem_lat));
        end
        #1;
        check("m_req", m_req, e_mreq);
        check("i_ok", i_ok, e_iok);
        check("d_ok", d_ok, e_dok);
        check("stall", stall, (i_req & !e_iok) | (d_req & !e_dok));
        if (e_mreq) begin
            check("m_addr", m_addr, e_addr);
            check("m_write", m_write, e_write);
            check("m_wdata", m_wdata, e_wdata);
            check("m_strobe", m_strobe, e_strobe);
        end
        check("i_rdata", i_rdata, e_irdata);
        check("d_rdata", d_rdata, e_drdata);
`ifdef ARB_PERF_EN
        check("i_wait_cnt", i_wait_cnt, e_iwait);
        check("d_wait_cnt", d_wait_cnt, e_dwait);
        obs_iwait = i_wait_cnt;
`endif
        if (i_ok) order = {order, "I"};
        if (d_ok) order = {order, "D"};
        last_iok = e_iok;
        last_dok = e_dok;
        @(posedge clk);
        if (i_req && !e_iok && e_iwait != 32'hFFFF_FFFF) e_iwait = e_iwait + 32'd1;
        if (d_req && !e_dok && e_dwait != 32'hFFFF_FFFF) e_dwait = e_dwait + 32'd1;
        if (e_mreq && m_ok) begin
            k_cyc = cyc;
            if (!act_d) e_irdata = m_rdata;
            else if (!e_write) e_drdata = m_rdata;
        end else if (e_iok || e_dok) begin
            act = 0;
        end else if (!act) begin
            arbitrate();
        end
        cyc++;
        #1;
        if (auto_req) drive_auto();
    endtask

    task automatic run_until_ok(input bit want_d, input int budget, output int n);
        bit seen;
        seen = 0;
        n = 0;
        while (!seen && n < budget) begin
            step();
            n++;
            seen = want_d ? last_dok : last_iok;
        end
        checks++;
        assert (seen) else begin
            errors++;
            $error("FAIL %s_ok_timeout observed=none expected=pulse", want_d ? "d" : "i");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int n;
        int dcount;
        logic [31:0] iwait_base;

        resetn = 0; i_req = 0; i_addr = '0; d_req = 0; d_write = 0;
        d_addr = '0; d_wdata = '0; d_strobe = '0; m_ok = 0; m_rdata = '0;
        mem_lat = 1; mem_rand = 0; auto_req = 0; spurious = 0; order = "";
        obs_iwait = '0; iwait_base = '0;
        model_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_req", m_req, 0);
        check("rst_i_ok", i_ok, 0);
        check("rst_d_ok", d_ok, 0);
        check("rst_stall", stall, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_i_rdata", i_rdata, 0);
        resetn = 1;

        // D store alone, memory answers 2 cycles into the access.
        d_req = 1; d_write = 1; d_addr = 32'h8000_0010; d_wdata = 32'hDEAD_BEEF; d_strobe = 4'hF;
        mem_lat = 2;
        run_until_ok(1, 20, n);
        check("d_store_cycles", n, 4);
        d_req = 0; d_write = 0;

        // Both held: starvation guard interleaves fetch every LIMIT data grants.
        mem_lat = 1; order = "";
        i_req = 1; i_addr = 32'h0000_1000;
        d_req = 1; d_addr = 32'h0000_2000; d_strobe = 4'h3;
        n = 0;
        while (order.len() < 10 && n < 80) begin
            step();
            n++;
        end
        checks++;
        assert (order == "DDDDIDDDDI") else begin
            errors++;
            $error("FAIL grant_order observed=%s expected=DDDDIDDDDI", order);
        end
        i_req = 0; d_req = 0;

        // Fetch alone from the boot vector.
        m_rdata = 32'h3C1D_8000; mem_lat = 1;
        i_req = 1; i_addr = 32'hBFC0_0000;
        run_until_ok(0, 20, n);
        check("i_fetch_cycles", n, 3);
        i_req = 0;
        check("i_rdata_boot", i_rdata, 32'h3C1D_8000);

        // Spurious m_ok while idle is ignored.
        spurious = 1;
        repeat (3) step();
        spurious = 0;
        step();

        // Fetch waits behind three back-to-back data accesses.
`ifdef ARB_PERF_EN
        iwait_base = i_wait_cnt;
`endif
        d_req = 1; d_write = 0; d_addr = 32'h0000_3000;
        step();
        i_req = 1; i_addr = 32'h0000_4000;
        n = 0; dcount = 0;
        while (!last_iok && n < 40) begin
            step();
            n++;
            if (last_dok) begin
                dcount++;
                if (dcount == 3) d_req = 0;
            end
        end
        check("starve_wait_d_count", dcount, 3);
        check("starve_wait_i_done", last_iok, 1);
        i_req = 0;
`ifdef ARB_PERF_EN
        check("i_wait_10", obs_iwait - iwait_base, 32'd10);
`endif

        // Reset in the middle of a D load.
        mem_lat = 8;
        d_req = 1; d_write = 0; d_addr = 32'h0000_5000;
        step();
        predict();
        #1;
        check("pre_rst_m_req", m_req, e_mreq);
        resetn = 0;
        #1;
        check("mid_rst_m_req", m_req, 0);
        check("mid_rst_d_ok", d_ok, 0);
        check("mid_rst_stall", stall, 0);
        check("mid_rst_m_addr", m_addr, 0);
        d_req = 0;
        @(posedge clk);
        #1;
        resetn = 1;
        model_reset();
        m_rdata = 32'h1234_5678; mem_lat = 2;
        d_req = 1; d_addr = 32'h0000_6000;
        run_until_ok(1, 20, n);
        d_req = 0;
        check("post_rst_d_rdata", d_rdata, 32'h1234_5678);

        // Randomized traffic against the model.
        mem_rand = 1; auto_req = 1;
        repeat (3000) step();
        auto_req = 0; mem_rand = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
